tcpc_reg_bank: RTL and testbench

TCPC_REG_BANK -- requirements
Module: tcpc_reg_bank

---
 rtl/tcpc_regs_pkg.sv | 20 ++
 rtl/tcpc_alert_unit.sv | 52 +++++
 rtl/tcpc_reg_bank.sv | 146 ++++++++++++++
 tb/tb_tcpc_reg_bank.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/tcpc_regs_pkg.sv
// Shared address map and handshake FSM encoding for the TCPC register bank.
package tcpc_regs_pkg;

    localparam logic [7:0] ADDR_VENDOR_ID    = 8'h00;
    localparam logic [7:0] ADDR_PRODUCT_ID   = 8'h02;
    localparam logic [7:0] ADDR_DEVICE_ID    = 8'h04;
    localparam logic [7:0] ADDR_ALERT_L      = 8'h10;
    localparam logic [7:0] ADDR_ALERT_H      = 8'h11;
    localparam logic [7:0] ADDR_ALERT_MASK_L = 8'h12;
    localparam logic [7:0] ADDR_ALERT_MASK_H = 8'h13;
    localparam logic [7:0] ADDR_RW_FIRST     = 8'h14;
    localparam logic [7:0] ADDR_RW_LAST      = 8'h7F;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RELEASE = 2'd2
    } tcpc_state_e;

endpackage

// File: rtl/tcpc_alert_unit.sv
// Alert event register (write-1-to-clear), alert mask and registered ALERT output.
// Byte select: 0/1 = alert low/high, 2/3 = mask low/high.
module tcpc_alert_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] alert_set,
    input  logic        wr_en,
    input  logic [1:0]  wr_sel,
    input  logic [7:0]  wr_data,
    output logic [15:0] alert_reg,
    output logic [15:0] alert_mask,
    output logic        alert
);

    logic [15:0] alert_reg_q, alert_reg_d;
    logic [15:0] alert_mask_q, alert_mask_d;
    logic [15:0] clr;
    logic        alert_q, alert_d;

    always_comb begin
        clr          = 16'h0000;
        alert_mask_d = alert_mask_q;
        if (wr_en) begin
            case (wr_sel)
                2'd0:    clr[7:0]            = wr_data;
                2'd1:    clr[15:8]           = wr_data;
                2'd2:    alert_mask_d[7:0]   = wr_data;
                default: alert_mask_d[15:8]  = wr_data;
            endcase
        end
        // a hardware set landing on the same edge as a clear wins
        alert_reg_d = (alert_reg_q & ~clr) | alert_set;
        alert_d     = |(alert_reg_q & alert_mask_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alert_reg_q  <= 16'h0000;
            alert_mask_q <= 16'hFFFF;
            alert_q      <= 1'b0;
        end else begin
            alert_reg_q  <= alert_reg_d;
            alert_mask_q <= alert_mask_d;
            alert_q      <= alert_d;
        end
    end

    assign alert_reg  = alert_reg_q;
    assign alert_mask = alert_mask_q;
    assign alert      = alert_q;

endmodule

// File: rtl/tcpc_reg_bank.sv
// TCPC register bank: request/ack handshake in front of ID, alert and storage registers.
// The alert unit is built only when TCPC_REG_BANK_ALERT_EN is defined; otherwise 0x10-0x13 are storage.
//
// state      | meaning
// ST_IDLE    | waiting for REQUEST; ADDR/RNW/WR_DATA captured on exit
// ST_ACCESS  | access performed; write, ACK and RD_DATA all registered on exit
// ST_RELEASE | ACK visible for its first cycle; waiting for REQUEST to drop
module tcpc_reg_bank
    import tcpc_regs_pkg::*;
#(
    parameter logic [15:0] VENDOR_ID  = 16'h0000,
    parameter logic [15:0] PRODUCT_ID = 16'h0000,
    parameter logic [15:0] DEVICE_ID  = 16'h0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQUEST,
    input  logic        RNW,
    input  logic [7:0]  ADDR,
    input  logic [7:0]  WR_DATA,
    output logic [7:0]  RD_DATA,
    output logic        ACK,
    input  logic [15:0] ALERT_SET,
    output logic        ALERT
);

`ifdef TCPC_REG_BANK_ALERT_EN
    localparam logic [7:0] STORE_FIRST = ADDR_RW_FIRST;
`else
    localparam logic [7:0] STORE_FIRST = ADDR_ALERT_L;
`endif

    tcpc_state_e state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        rnw_q, rnw_d;
    logic        ack_q, ack_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic [7:0]  rd_byte;
    logic        commit;
    logic        in_store;
    logic [7:0]  mem_q [STORE_FIRST:ADDR_RW_LAST];
    logic [7:0]  mem_d [STORE_FIRST:ADDR_RW_LAST];

    assign commit   = (state_q == ST_ACCESS) && !rnw_q;
    assign in_store = (addr_q >= STORE_FIRST) && (addr_q <= ADDR_RW_LAST);

`ifdef TCPC_REG_BANK_ALERT_EN
    logic [15:0] alert_reg;
    logic [15:0] alert_mask;
    logic        alert_hit;

    assign alert_hit = (addr_q[7:2] == ADDR_ALERT_L[7:2]);

    tcpc_alert_unit u_alert (
        .clk        (CLK),
        .reset      (RESET),
        .alert_set  (ALERT_SET),
        .wr_en      (commit && alert_hit),
        .wr_sel     (addr_q[1:0]),
        .wr_data    (wdata_q),
        .alert_reg  (alert_reg),
        .alert_mask (alert_mask),
        .alert      (ALERT)
    );
`else
    logic unused_alert_set;
    assign unused_alert_set = ^ALERT_SET;
    assign ALERT = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rnw_d   = rnw_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (REQUEST) begin
                    state_d = ST_ACCESS;
                    addr_d  = ADDR;
                    rnw_d   = RNW;
                    wdata_d = WR_DATA;
                end
            end
            ST_ACCESS:  state_d = ST_RELEASE;
            ST_RELEASE: if (!REQUEST) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_byte = 8'h00;
        if (in_store) rd_byte = mem_q[addr_q[6:0]];
        case (addr_q)
            ADDR_VENDOR_ID:          rd_byte = VENDOR_ID[7:0];
            ADDR_VENDOR_ID + 8'd1:   rd_byte = VENDOR_ID[15:8];
            ADDR_PRODUCT_ID:         rd_byte = PRODUCT_ID[7:0];
            ADDR_PRODUCT_ID + 8'd1:  rd_byte = PRODUCT_ID[15:8];
            ADDR_DEVICE_ID:          rd_byte = DEVICE_ID[7:0];
            ADDR_DEVICE_ID + 8'd1:   rd_byte = DEVICE_ID[15:8];
            default: ;
        endcase
`ifdef TCPC_REG_BANK_ALERT_EN
        if (alert_hit) begin
            case (addr_q[1:0])
                2'd0:    rd_byte = alert_reg[7:0];
                2'd1:    rd_byte = alert_reg[15:8];
                2'd2:    rd_byte = alert_mask[7:0];
                default: rd_byte = alert_mask[15:8];
            endcase
        end
`endif
    end

    always_comb begin
        mem_d = mem_q;
        if (commit && in_store) mem_d[addr_q[6:0]] = wdata_q;
        ack_d     = (state_q == ST_ACCESS);
        rd_data_d = ((state_q == ST_ACCESS) && rnw_q) ? rd_byte : 8'h00;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            addr_q    <= 8'h00;
            rnw_q     <= 1'b0;
            wdata_q   <= 8'h00;
            ack_q     <= 1'b0;
            rd_data_q <= 8'h00;
            mem_q     <= '{default: 8'h00};
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rnw_q     <= rnw_d;
            wdata_q   <= wdata_d;
            ack_q     <= ack_d;
            rd_data_q <= rd_data_d;
            mem_q     <= mem_d;
        end
    end

    assign ACK     = ack_q;
    assign RD_DATA = rd_data_q;

endmodule

// File: tb/tb_tcpc_reg_bank.sv
// Scoreboard bench for tcpc_reg_bank; expectations follow TCPC_REG_BANK_ALERT_EN when defined.
module tb_tcpc_reg_bank;

    localparam logic [15:0] VID = 16'h1234;
    localparam logic [15:0] PID = 16'h5678;
    localparam logic [15:0] DID = 16'h9ABC;
`ifdef TCPC_REG_BANK_ALERT_EN
    localparam bit ALERT_EN = 1'b1;
`else
    localparam bit ALERT_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        REQUEST = 1'b0;
    logic        RNW = 1'b0;
    logic [7:0]  ADDR = 8'h00;
    logic [7:0]  WR_DATA = 8'h00;
    logic [15:0] ALERT_SET = 16'h0000;
    logic [7:0]  RD_DATA;
    logic        ACK;
    logic        ALERT;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [7:0]  sb_q [$];
    bit          ack_prev = 1'b0;

    tcpc_reg_bank #(
        .VENDOR_ID  (VID),
        .PRODUCT_ID (PID),
        .DEVICE_ID  (DID)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .REQUEST   (REQUEST),
        .RNW       (RNW),
        .ADDR      (ADDR),
        .WR_DATA   (WR_DATA),
        .RD_DATA   (RD_DATA),
        .ACK       (ACK),
        .ALERT_SET (ALERT_SET),
        .ALERT     (ALERT)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Monitor: every ACK pops one expected RD_DATA; outside ACK RD_DATA must be zero.
    always @(negedge CLK) begin
        if (!RESET) begin
            if (ACK) begin
                if (sb_q.size() == 0) check_val("ack_unexpected", ACK, 0);
                else check_val("rd_data", RD_DATA, sb_q.pop_front());
            end else begin
                check_val("rd_idle", RD_DATA, 0);
            end
            if (ack_prev) check_val("ack_width", ACK, 0);
        end
        ack_prev = (ACK === 1'b1) && !RESET;
    end

    // Called just after a rising edge. Inputs are scrambled after capture to prove they are ignored.
    task automatic xfer(input bit rnw, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] exp, input int hold, input logic [15:0] set_at_commit);
        sb_q.push_back(rnw ? exp : 8'h00);
        RNW = rnw; ADDR = a; WR_DATA = d; REQUEST = 1'b1;
        @(posedge CLK); #1;
        RNW = ~rnw; ADDR = ~a; WR_DATA = ~d; ALERT_SET = set_at_commit;
        @(negedge CLK); check_val("ack_early", ACK, 0);
        @(posedge CLK); #1;
        ALERT_SET = 16'h0000;
        @(negedge CLK); check_val("ack_latency", ACK, 1);
        repeat (hold) @(posedge CLK);
        @(posedge CLK); #1;
        REQUEST = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp);
        xfer(1'b1, a, 8'h00, exp, 0, 16'h0000);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        xfer(1'b0, a, d, 8'h00, 0, 16'h0000);
    endtask

    task automatic pulse_alert(input logic [15:0] bits, input logic exp_before, input logic exp_after);
        ALERT_SET = bits;
        @(posedge CLK); #1;
        ALERT_SET = 16'h0000;
        @(negedge CLK); check_val("alert_lag", ALERT, exp_before);
        @(posedge CLK); #1;
        @(negedge CLK); check_val("alert_rise", ALERT, exp_after);
        @(posedge CLK); #1;
    endtask

    task automatic reset_abort();
        RNW = 1'b0; ADDR = 8'h30; WR_DATA = 8'h77; REQUEST = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b1; ALERT_SET = 16'hFFFF;
        @(posedge CLK); #1;
        RESET = 1'b0; ALERT_SET = 16'h0000; REQUEST = 1'b0;
        @(negedge CLK); check_val("abort_ack", ACK, 0);
        @(posedge CLK); #1;
        @(negedge CLK); check_val("abort_alert", ALERT, 0);
        @(posedge CLK); #1;
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check_val("rst_ack", ACK, 0);
        check_val("rst_rd_data", RD_DATA, 0);
        check_val("rst_alert", ALERT, 0);
        @(posedge CLK); #1;

        rd(8'h12, ALERT_EN ? 8'hFF : 8'h00);
        rd(8'h13, ALERT_EN ? 8'hFF : 8'h00);
        rd(8'h14, 8'h00);

        wr(8'h20, 8'hA5);
        rd(8'h20, 8'hA5);
        wr(8'h7F, 8'h3C);
        rd(8'h7F, 8'h3C);
        rd(8'h20, 8'hA5);

        rd(8'h00, 8'h34);
        rd(8'h01, 8'h12);
        rd(8'h02, 8'h78);
        rd(8'h05, 8'h9A);
        wr(8'h00, 8'hFF);
        rd(8'h00, 8'h34);

        rd(8'h10, 8'h00);
        pulse_alert(16'h0001, 1'b0, ALERT_EN);
        rd(8'h10, ALERT_EN ? 8'h01 : 8'h00);
        wr(8'h10, 8'h01);
        rd(8'h10, ALERT_EN ? 8'h00 : 8'h01);
        @(negedge CLK); check_val("alert_cleared", ALERT, 0);
        @(posedge CLK); #1;

        pulse_alert(16'h0001, 1'b0, ALERT_EN);
        xfer(1'b0, 8'h10, 8'h01, 8'h00, 0, 16'h0001);
        rd(8'h10, 8'h01);
        @(negedge CLK); check_val("alert_set_wins", ALERT, ALERT_EN);
        @(posedge CLK); #1;

        wr(8'h12, 8'h00);
        @(negedge CLK); check_val("alert_masked", ALERT, 0);
        @(posedge CLK); #1;
        rd(8'h12, 8'h00);
        pulse_alert(16'h0200, 1'b0, ALERT_EN);
        rd(8'h11, ALERT_EN ? 8'h02 : 8'h00);

        xfer(1'b0, 8'h90, 8'h55, 8'h00, 3, 16'h0000);
        rd(8'h90, 8'h00);
        rd(8'hFF, 8'h00);

        reset_abort();
        rd(8'h30, 8'h00);
        rd(8'h10, 8'h00);
        rd(8'h11, 8'h00);
        rd(8'h12, ALERT_EN ? 8'hFF : 8'h00);
        rd(8'h20, 8'h00);

        repeat (2) @(posedge CLK);
        check_val("sb_drained", 16'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
